aer_spike_tx: RTL and testbench
===============================

Name: aer_spike_tx

Overview:
- Transmit side of the neuron layer's spike interface.
- Accepts one spike vector per timestep, one bit per neuron.
- Serializes the vector into address-event (AER) packets: neuron index plus timestep stamp, lowest index first, over a valid/ready link.
- Sits between the neuron array's fire outputs and the inter-layer event bus.

Parameters:
- N_NEURONS, 16, number of neurons (spike vector width), >= 2
- ADDR_W, $clog2(N_NEURONS), width of the emitted neuron address
- TS_W, 8, width of the timestep stamp counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- spk_in  in  N_NEURONS  spike vector for the current timestep
- spk_valid  in  1  spk_in is a complete timestep frame
- spk_ready  out  1  block can accept a frame this cycle
- aer_addr  out  ADDR_W  neuron index of the current event
- aer_ts  out  TS_W  timestep stamp of the current event
- aer_valid  out  1  event on aer_addr/aer_ts is valid
- aer_ready  in  1  downstream accepts the event
- frame_done  out  1  one-cycle pulse when a frame is fully sent
- ovf  out  1  sticky: a frame arrived while spk_ready was 0
- ovf_clr  in  1  clears ovf

Behaviour:
- Reset (rst=0, asynchronous): all outputs and state clear immediately.
  - State = IDLE, pending = 0, ts counter = 0.
  - aer_valid = 0, aer_addr = 0, aer_ts = 0, frame_done = 0, ovf = 0.
  - spk_ready = 1 once reset releases.
  - Reset mid-frame discards the remaining events.
- States: IDLE, SEND.
- spk_ready = 1 only in IDLE.
- Frame accept (IDLE and spk_valid=1):
  - pending <= spk_in; aer_ts register <= ts counter; ts counter increments, wrapping at 2^TS_W-1 -> 0.
  - spk_in nonzero: go to SEND. Next cycle aer_valid=1 and aer_addr = lowest set index of spk_in. Latency is 1 cycle.
  - spk_in all-zero: stay in IDLE. frame_done pulses the next cycle; no events are emitted; ts still increments.
- SEND:
  - aer_valid held at 1. aer_addr and aer_ts stay stable until handshake (aer_valid & aer_ready).
  - On handshake: the current bit is cleared in pending.
    - Other bits remain: aer_addr loads the next-lowest set index the next cycle and aer_valid stays 1. Throughput is one event per cycle.
    - Last bit: aer_valid <= 0, frame_done pulses the next cycle, state <= IDLE, spk_ready = 1 that same next cycle.
  - aer_ready held at 0 stalls indefinitely; no timeout.
- A frame with K set bits completes in exactly K cycles of aer_ready=1, plus 1 cycle of accept latency.
- Overflow:
  - spk_valid=1 while spk_ready=0: the frame is dropped, ovf <= 1, and the ts counter does not increment.
  - ovf_clr=1 clears ovf. If a drop and ovf_clr occur in the same cycle, set wins.
- spk_in and spk_valid are sampled only when spk_ready=1. spk_in changes during SEND have no effect.
- Width rules:
  - aer_addr never exceeds N_NEURONS-1.
  - Non-power-of-two N_NEURONS is legal; unused address codes are never emitted.

Decomposition:
- neuron_pkg holds:
  - typedef enum logic {IDLE, SEND} aer_tx_state_t
  - localparam defaults N_NEURONS_DEF=16 and TS_W_DEF=8, shared with the receive side
- One sub-module: prio_enc_lsb.
  - Parameterized N; combinational lowest-set-bit encoder.
  - Outputs idx[$clog2(N)-1:0] and any.
  - Used to pick the next address from pending with the current bit masked.

Test Plan:
- Reset then single frame:
  - Stimulus: spk_in=16'h0091, aer_ready=1.
  - Required: aer_addr 0,4,7 on three consecutive cycles, all with aer_ts=0; frame_done pulse one cycle after addr 7; spk_ready returns to 1.
- Backpressure:
  - Stimulus: spk_in=16'h8001; aer_ready low 5 cycles, then high.
  - Required: aer_addr=0 and aer_ts held stable for all 5 stall cycles; then addr 15; exactly 2 handshakes.
- Empty frame and ts wrap:
  - Stimulus: 256 all-zero frames, then spk_in=16'h0002.
  - Required: no aer_valid during the zero frames; 256 frame_done pulses; event addr=1 with aer_ts=0 (wrapped).
- Overflow:
  - Stimulus: spk_valid=1 during SEND of frame 16'hFFFF with aer_ready=0.
  - Required: ovf=1; 16 events emitted, all with the original ts; the dropped frame produces no events.
  - Then ovf_clr with a simultaneous new drop: ovf stays 1.
- Reset mid-frame:
  - Stimulus: rst=0 asynchronously after 2 of 8 events.
  - Required: aer_valid=0 with no clock edge.
  - After release: spk_ready=1, ts=0, and the next frame's lowest bit is emitted first.
- All-ones frame:
  - Stimulus: 16'hFFFF, aer_ready=1.
  - Required: addresses 0..15 on back-to-back cycles; frame_done exactly once, one cycle after addr 15.

Source files
------------

// File: rtl/neuron_pkg.sv
// Types and default sizes shared by the spike transmit and receive sides of
// the neuron layer.
package neuron_pkg;

  localparam int N_NEURONS_DEF = 16;
  localparam int TS_W_DEF      = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } aer_tx_state_t;

endpackage

// File: rtl/aer_spike_tx_prio_enc_lsb.sv
// Combinational lowest-set-bit encoder: idx is the index of the lowest set
// bit of in_i, any flags that at least one bit is set.
module prio_enc_lsb #(
  parameter int N = 16
) (
  input  logic [N-1:0]         in_i,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);

  localparam int IW = $clog2(N);

  // Scan high to low so the lowest set bit is the last write and wins.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_i[i]) idx_o = IW'(i);
    end
  end

  assign any_o = |in_i;

endmodule

// File: rtl/aer_spike_tx.sv
// Serializes one spike vector per timestep into AER events (neuron index +
// timestep stamp), lowest index first, over a valid/ready link.
module aer_spike_tx
  import neuron_pkg::*;
#(
  parameter int N_NEURONS = N_NEURONS_DEF,
  parameter int ADDR_W    = $clog2(N_NEURONS),
  parameter int TS_W      = TS_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_NEURONS-1:0] spk_in,
  input  logic                 spk_valid,
  output logic                 spk_ready,
  output logic [ADDR_W-1:0]    aer_addr,
  output logic [TS_W-1:0]      aer_ts,
  output logic                 aer_valid,
  input  logic                 aer_ready,
  output logic                 frame_done,
  output logic                 ovf,
  input  logic                 ovf_clr
);

  aer_tx_state_t          state_q, state_d;
  logic [N_NEURONS-1:0]   pending_q, pending_d;
  logic [TS_W-1:0]        ts_cnt_q, ts_cnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [TS_W-1:0]        ts_q, ts_d;
  logic                   valid_q, valid_d;
  logic                   done_q, done_d;
  logic                   ovf_q, ovf_d;

  logic [N_NEURONS-1:0]   cur_oh;
  logic [N_NEURONS-1:0]   pend_masked;
  logic [N_NEURONS-1:0]   enc_in;
  logic [ADDR_W-1:0]      enc_idx;
  logic                   enc_any;

  // One-hot of the address currently on the link; removed from pending on
  // handshake so the encoder already sees the next candidate.
  always_comb begin
    cur_oh = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      cur_oh[i] = (addr_q == ADDR_W'(i));
    end
  end

  assign pend_masked = pending_q & ~cur_oh;
  assign enc_in      = (state_q == IDLE) ? spk_in : pend_masked;

  prio_enc_lsb #(
    .N (N_NEURONS)
  ) u_enc (
    .in_i  (enc_in),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  assign spk_ready  = (state_q == IDLE);
  assign aer_addr   = addr_q;
  assign aer_ts     = ts_q;
  assign aer_valid  = valid_q;
  assign frame_done = done_q;
  assign ovf        = ovf_q;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    ts_cnt_d  = ts_cnt_q;
    addr_d    = addr_q;
    ts_d      = ts_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;

    // A drop in the same cycle as a clear must leave ovf set.
    if (ovf_clr)                ovf_d = 1'b0;
    if (spk_valid && !spk_ready) ovf_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (spk_valid) begin
          pending_d = spk_in;
          ts_d      = ts_cnt_q;
          ts_cnt_d  = ts_cnt_q + TS_W'(1);
          if (enc_any) begin
            state_d = SEND;
            addr_d  = enc_idx;
            valid_d = 1'b1;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      SEND: begin
        if (aer_ready) begin
          pending_d = pend_masked;
          if (enc_any) begin
            addr_d  = enc_idx;
          end else begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      ts_cnt_q  <= '0;
      addr_q    <= '0;
      ts_q      <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ts_cnt_q  <= ts_cnt_d;
      addr_q    <= addr_d;
      ts_q      <= ts_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_aer_spike_tx.sv
// Directed bench for aer_spike_tx: frame serialization, backpressure, empty
// frames with stamp wrap, overflow, async reset mid-frame, all-ones frame.
module tb_aer_spike_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] spk_in;
  logic        spk_valid;
  logic        spk_ready;
  logic [3:0]  aer_addr;
  logic [7:0]  aer_ts;
  logic        aer_valid;
  logic        aer_ready;
  logic        frame_done;
  logic        ovf;
  logic        ovf_clr;

  int n_run  = 0;
  int n_fail = 0;
  int hs_cnt = 0;
  int fd_cnt = 0;
  int vl_cnt = 0;
  logic [3:0] q_addr[$];
  logic [7:0] q_ts[$];

  always #5 clk = ~clk;

  aer_spike_tx #(.N_NEURONS(16), .TS_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .spk_in     (spk_in),
    .spk_valid  (spk_valid),
    .spk_ready  (spk_ready),
    .aer_addr   (aer_addr),
    .aer_ts     (aer_ts),
    .aer_valid  (aer_valid),
    .aer_ready  (aer_ready),
    .frame_done (frame_done),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
  );

  always @(posedge clk) begin
    if (aer_valid && aer_ready) begin
      hs_cnt++;
      q_addr.push_back(aer_addr);
      q_ts.push_back(aer_ts);
    end
    if (frame_done) fd_cnt++;
    if (aer_valid)  vl_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    hs_cnt = 0; fd_cnt = 0; vl_cnt = 0;
    q_addr.delete(); q_ts.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    spk_in = '0; spk_valid = 1'b0; aer_ready = 1'b0; ovf_clr = 1'b0;
    do_reset();

    // reset state
    chk("rst_valid", aer_valid, 0);
    chk("rst_addr", aer_addr, 0);
    chk("rst_ts", aer_ts, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ready", spk_ready, 1);

    // single frame 0x0091 -> 0,4,7
    spk_in = 16'h0091; spk_valid = 1'b1; aer_ready = 1'b1;
    @(negedge clk);
    spk_valid = 1'b0;
    chk("f1_v0", aer_valid, 1);
    chk("f1_a0", aer_addr, 0);
    chk("f1_t0", aer_ts, 0);
    chk("f1_busy", spk_ready, 0);
    @(negedge clk);
    chk("f1_a1", aer_addr, 4);
    chk("f1_t1", aer_ts, 0);
    @(negedge clk);
    chk("f1_a2", aer_addr, 7);
    chk("f1_d2", frame_done, 0);
    @(negedge clk);
    chk("f1_done", frame_done, 1);
    chk("f1_vend", aer_valid, 0);
    chk("f1_rdy", spk_ready, 1);
    @(negedge clk);
    chk("f1_done_clr", frame_done, 0);

    // backpressure 0x8001, 5 stalled cycles; stamp is now 1
    clr_mon();
    spk_in = 16'h8001; spk_valid = 1'b1; aer_ready = 1'b0;
    @(negedge clk);
    spk_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_stall_v", aer_valid, 1);
      chk("bp_stall_a", aer_addr, 0);
      chk("bp_stall_t", aer_ts, 1);
      if (i == 4) aer_ready = 1'b1;
      @(negedge clk);
    end
    chk("bp_a15", aer_addr, 15);
    chk("bp_v15", aer_valid, 1);
    @(negedge clk);
    chk("bp_done", frame_done, 1);
    @(negedge clk);
    chk("bp_hs", hs_cnt, 2);

    // 256 empty frames from reset wrap the stamp back to 0
    do_reset();
    clr_mon();
    spk_in = 16'h0000; spk_valid = 1'b1;
    for (int i = 0; i < 256; i++) @(negedge clk);
    spk_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("zf_done_cnt", fd_cnt, 256);
    chk("zf_no_valid", vl_cnt, 0);
    spk_in = 16'h0002; spk_valid = 1'b1;
    @(negedge clk);
    spk_valid = 1'b0;
    chk("zf_v", aer_valid, 1);
    chk("zf_a", aer_addr, 1);
    chk("zf_ts_wrap", aer_ts, 0);
    @(negedge clk);
    chk("zf_end", frame_done, 1);

    // overflow during a stalled 0xFFFF frame (stamp 1)
    @(negedge clk);
    clr_mon();
    spk_in = 16'hFFFF; spk_valid = 1'b1; aer_ready = 1'b0;
    @(negedge clk);
    chk("ov_t", aer_ts, 1);
    chk("ov_busy", spk_ready, 0);
    spk_in = 16'h00F0;
    @(negedge clk);
    chk("ov_set", ovf, 1);
    spk_valid = 1'b0; aer_ready = 1'b1;
    for (int i = 0; i < 17; i++) @(negedge clk);
    chk("ov_hs16", hs_cnt, 16);
    for (int i = 0; i < 16; i++) begin
      chk("ov_ev_a", (i < q_addr.size()) ? 32'(q_addr[i]) : 32'hFFFF, i);
      chk("ov_ev_t", (i < q_ts.size()) ? 32'(q_ts[i]) : 32'hFFFF, 1);
    end
    @(negedge clk);
    @(negedge clk);
    chk("ov_nodrop_ev", hs_cnt, 16);
    chk("ov_idle_v", aer_valid, 0);
    chk("ov_sticky", ovf, 1);
    spk_in = 16'hFFFF; spk_valid = 1'b1; aer_ready = 1'b0;
    @(negedge clk);
    chk("ov_ts_noinc", aer_ts, 2);
    ovf_clr = 1'b1;
    @(negedge clk);
    chk("ov_set_wins", ovf, 1);
    spk_valid = 1'b0;
    @(negedge clk);
    chk("ov_clr", ovf, 0);
    ovf_clr = 1'b0;

    // async reset after 2 of 8 events
    do_reset();
    spk_in = 16'h00FF; spk_valid = 1'b1; aer_ready = 1'b1;
    @(negedge clk);
    spk_valid = 1'b0;
    chk("mr_a0", aer_addr, 0);
    @(negedge clk);
    chk("mr_a1", aer_addr, 1);
    @(negedge clk);
    chk("mr_a2", aer_addr, 2);
    #2 rst = 1'b0;
    #1;
    chk("mr_async_v", aer_valid, 0);
    chk("mr_async_a", aer_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    chk("mr_rdy", spk_ready, 1);
    chk("mr_ts", aer_ts, 0);
    spk_in = 16'h0A00; spk_valid = 1'b1;
    @(negedge clk);
    spk_valid = 1'b0;
    chk("mr_n_a", aer_addr, 9);
    chk("mr_n_t", aer_ts, 0);
    @(negedge clk);
    chk("mr_n_a2", aer_addr, 11);
    @(negedge clk);
    chk("mr_n_done", frame_done, 1);
    @(negedge clk);

    // all-ones frame back to back
    clr_mon();
    spk_in = 16'hFFFF; spk_valid = 1'b1; aer_ready = 1'b1;
    @(negedge clk);
    spk_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("ao_a", aer_addr, i);
      chk("ao_v", aer_valid, 1);
      chk("ao_nodone", frame_done, 0);
      @(negedge clk);
    end
    chk("ao_done", frame_done, 1);
    chk("ao_vend", aer_valid, 0);
    @(negedge clk);
    chk("ao_done_clr", frame_done, 0);
    chk("ao_done_once", fd_cnt, 1);
    chk("ao_hs", hs_cnt, 16);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
